multi_ultrasonic_ranger: RTL and testbench

MULTI_ULTRASONIC_RANGER -- requirements
Module: multi_ultrasonic_ranger

---
 rtl/multi_ultrasonic_ranger_if.sv | 18 +
 rtl/multi_ultrasonic_ranger.sv | 161 ++++++++++++++++
 tb/tb_multi_ultrasonic_ranger.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_ultrasonic_ranger_if.sv
// rtl/multi_ultrasonic_ranger_if.sv - control, echo and result signals of the multi-channel ultrasonic ranger
interface multi_ultrasonic_ranger_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 23
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                  ctrl;
  logic [N_CH-1:0]       echo;
  logic [N_CH-1:0]       trigger;
  logic [3*N_CH-1:0]     dist_class;
  logic [CNT_W*N_CH-1:0] echo_cycles;
  logic                  valid;
  logic [IDX_W-1:0]      ch_idx;

  modport master (output ctrl, echo, input trigger, dist_class, echo_cycles, valid, ch_idx);
  modport slave  (input ctrl, echo, output trigger, dist_class, echo_cycles, valid, ch_idx);
endinterface

// File: rtl/multi_ultrasonic_ranger.sv
// rtl/multi_ultrasonic_ranger.sv - round-robin ultrasonic ranger with binned, debounced distance classes
module multi_ultrasonic_ranger #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 23,
  parameter int TRIG_CYC    = 1000,
  parameter int TIMEOUT_CYC = 3000000,
  parameter int GAP_CYC     = 6000000,
  parameter int BIN_CYC     = 58000,
  parameter int CONFIRM     = 2
) (
  input  logic clk,
  input  logic reset,
  multi_ultrasonic_ranger_if.slave bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] BIN_LAST  = CNT_W'(BIN_CYC - 1);
  localparam logic [2:0]       CONF      = 3'(CONFIRM);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;
  state_t state, state_next;

  logic [N_CH-1:0]  sync1, sync2, sync_prev;
  logic [CNT_W-1:0] timer, cnt, sub;
  logic [2:0]       bin;
  logic [IDX_W-1:0] ch;
  logic             valid_r;
  logic [2:0]       dist_r   [N_CH];
  logic [2:0]       raw_r    [N_CH];
  logic [2:0]       rep_r    [N_CH];
  logic [CNT_W-1:0] cycles_r [N_CH];

  logic             echo_now, rise, fall, meas_end, timer_clr, ch_adv;
  logic [2:0]       end_raw, rep_next;
  logic [CNT_W-1:0] end_cycles;

  assign echo_now = sync2[ch];
  assign rise     = echo_now & ~sync_prev[ch];
  assign fall     = ~echo_now & sync_prev[ch];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // timer is shared: trigger length, then timeout from trigger fall, then gap
  always_comb begin
    state_next  = state;
    meas_end    = 1'b0;
    end_raw     = 3'd7;
    end_cycles  = '0;
    timer_clr   = 1'b0;
    ch_adv      = 1'b0;
    bus.trigger = '0;
    if (state == TRIG && bus.ctrl) bus.trigger[ch] = 1'b1;
    if (state != IDLE && !bus.ctrl) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.ctrl) begin
          state_next = TRIG;
          timer_clr  = 1'b1;
        end
        TRIG: if (timer == TRIG_LAST) begin
          state_next = WAIT_RISE;
          timer_clr  = 1'b1;
        end
        WAIT_RISE: begin
          if (timer == TO_LAST) begin
            meas_end   = 1'b1;
            state_next = GAP;
            timer_clr  = 1'b1;
          end else if (rise) begin
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (timer == TO_LAST) begin
            meas_end   = 1'b1;
            state_next = GAP;
            timer_clr  = 1'b1;
          end else if (fall) begin
            meas_end   = 1'b1;
            end_raw    = bin;
            end_cycles = cnt;
            state_next = GAP;
            timer_clr  = 1'b1;
          end
        end
        GAP: if (timer == GAP_LAST) begin
          ch_adv     = 1'b1;
          state_next = TRIG;
          timer_clr  = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rep_next = 3'd1;
    if (end_raw == raw_r[ch]) rep_next = (rep_r[ch] >= CONF) ? CONF : rep_r[ch] + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      timer     <= '0;
      cnt       <= '0;
      sub       <= '0;
      bin       <= '0;
      ch        <= '0;
      valid_r   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dist_r[i]   <= 3'd7;
        raw_r[i]    <= 3'd7;
        rep_r[i]    <= '0;
        cycles_r[i] <= '0;
      end
    end else begin
      sync1     <= bus.echo;
      sync2     <= sync1;
      sync_prev <= sync2;
      valid_r   <= meas_end;
      if (timer_clr)          timer <= '0;
      else if (state != IDLE) timer <= timer + CNT_W'(1);
      // the rise cycle itself is the first counted echo cycle
      if (state == WAIT_RISE && state_next == MEASURE) begin
        cnt <= CNT_W'(1);
        sub <= (BIN_CYC == 1) ? '0 : CNT_W'(1);
        bin <= (BIN_CYC == 1) ? 3'd1 : 3'd0;
      end else if (state == MEASURE && state_next == MEASURE) begin
        cnt <= cnt + CNT_W'(1);
        if (sub == BIN_LAST) begin
          sub <= '0;
          if (bin != 3'd6) bin <= bin + 3'd1;
        end else begin
          sub <= sub + CNT_W'(1);
        end
      end
      if (ch_adv) ch <= (ch == IDX_W'(N_CH - 1)) ? '0 : ch + IDX_W'(1);
      if (meas_end) begin
        cycles_r[ch] <= end_cycles;
        raw_r[ch]    <= end_raw;
        rep_r[ch]    <= rep_next;
        if (rep_next == CONF) dist_r[ch] <= end_raw;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign bus.dist_class[3*g +: 3]          = dist_r[g];
    assign bus.echo_cycles[CNT_W*g +: CNT_W] = cycles_r[g];
  end
  assign bus.valid  = valid_r;
  assign bus.ch_idx = ch;
endmodule

// File: tb/tb_multi_ultrasonic_ranger.sv
// tb/tb_multi_ultrasonic_ranger.sv - directed ping scenarios checked against a per-channel result model
module tb_multi_ultrasonic_ranger;
  localparam int N_CH = 2, CNT_W = 16, TRIG_CYC = 10, TIMEOUT_CYC = 6000;
  localparam int GAP_CYC = 200, BIN_CYC = 580, CONFIRM = 2;
  localparam int K_ECHO = 0, K_NONE = 1, K_STUCK = 2, K_DROP = 3, K_RESET = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vecs = 0, errs = 0;
  bit   started = 1'b0;

  multi_ultrasonic_ranger_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

  multi_ultrasonic_ranger #(
    .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC(GAP_CYC), .BIN_CYC(BIN_CYC), .CONFIRM(CONFIRM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; int raw; int cycles; int vcyc;} exp_t;
  typedef struct {int ch; int kind; int dly; int width; int lit_dist; int lit_cyc;} item_t;

  exp_t  expq[$];
  item_t items[$];
  int    hist [N_CH][$];
  int    mdist [N_CH];
  int    mcyc  [N_CH];
  exp_t  e;
  bit    same;
  int    sz;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    vecs++;
    if (act < exp - tol || act > exp + tol) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (cycle %0d)", name, act, exp, tol, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  endtask

  task automatic bail(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: wait bound expired, got no event, expected one (cycle %0d)", name, cyc);
    finish_run();
  endtask

  function automatic int raw_of(input int w);
    return (w / BIN_CYC > 6) ? 6 : w / BIN_CYC;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      hist[c].delete();
      mdist[c] = 7;
      mcyc[c]  = 0;
    end
    expq.delete();
  endtask

  task automatic add(input int ch, input int kind, input int dly, input int width,
                     input int lit_dist, input int lit_cyc);
    item_t it;
    it.ch = ch; it.kind = kind; it.dly = dly; it.width = width;
    it.lit_dist = lit_dist; it.lit_cyc = lit_cyc;
    items.push_back(it);
  endtask

  task automatic wait_trig_high(output int s);
    int n = 0;
    @(negedge clk);
    while (bus.trigger == '0) begin
      n++;
      if (n > 1000) bail("trigger_start");
      @(negedge clk);
    end
    s = cyc;
  endtask

  task automatic wait_trig_low(output int f);
    int n = 0;
    @(negedge clk);
    while (bus.trigger != '0) begin
      n++;
      if (n > TRIG_CYC + 10) bail("trigger_end");
      @(negedge clk);
    end
    f = cyc;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.valid) begin
      n++;
      if (n > budget) bail("valid_wait");
      @(negedge clk);
    end
  endtask

  // model: valid pops the expected result; a class is confirmed once it ends a run of CONFIRM equal results
  always @(negedge clk) begin
    if (started) begin
      if (bus.valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("valid_ch_idx", int'(bus.ch_idx), e.ch);
          chk("valid_latency", cyc, e.vcyc);
          hist[e.ch].push_back(e.raw);
          mcyc[e.ch] = e.cycles;
          sz = hist[e.ch].size();
          if (sz >= CONFIRM) begin
            same = 1'b1;
            for (int i = 0; i < CONFIRM; i++)
              if (hist[e.ch][sz-1-i] != e.raw) same = 1'b0;
            if (same) mdist[e.ch] = e.raw;
          end
        end
      end
      chk("trigger_onehot0", int'($onehot0(bus.trigger)), 1);
      for (int c = 0; c < N_CH; c++) begin
        chk("dist_class_model", int'(bus.dist_class[c*3 +: 3]), mdist[c]);
        chk_tol("echo_cycles_model", int'(bus.echo_cycles[c*CNT_W +: CNT_W]), mcyc[c], 2);
      end
    end
  end

  initial begin
    #(900000 * 10);
    bail("global_watchdog");
  end

  initial begin
    item_t it;
    int s, f, restart_ref;
    restart_ref = -1;
    model_reset();
    bus.ctrl = 1'b1;
    bus.echo = '0;

    add(0, K_ECHO,  50, 1300, 7, 1300);
    add(1, K_NONE,   0,    0, 7,    0);
    add(0, K_ECHO,  40, 1300, 2, 1300);
    add(1, K_NONE,   0,    0, 7,    0);
    add(0, K_ECHO,  20, 5000, 2, 5000);
    add(1, K_STUCK,  0,    0, 7,    0);
    add(0, K_ECHO,  20, 5000, 6, 5000);
    add(1, K_ECHO,  60,  700, 7,  700);
    add(0, K_DROP,  30,  300, 6, 5000);
    add(0, K_ECHO,  25,  600, 6,  600);
    add(1, K_ECHO,  60,  700, 1,  700);
    add(0, K_ECHO,  25,  600, 1,  600);
    add(1, K_RESET,  0,    0, 7,    0);
    add(0, K_ECHO,  50, 1300, 7, 1300);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_trigger", int'(bus.trigger), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_ch_idx", int'(bus.ch_idx), 0);
    chk("reset_dist_class", int'(bus.dist_class), 63);
    chk("reset_echo_cycles", int'(bus.echo_cycles), 0);
    started = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < items.size(); i++) begin
      it = items[i];
      if (it.kind == K_STUCK) bus.echo[it.ch] = 1'b1;
      wait_trig_high(s);
      chk("trigger_channel", int'(bus.trigger), 1 << it.ch);
      if (restart_ref >= 0) begin
        chk("restart_after_ctrl", int'((s - restart_ref) <= 2), 1);
        restart_ref = -1;
      end
      if (it.kind == K_RESET) begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 model_reset();
        @(negedge clk);
        chk("midreset_trigger", int'(bus.trigger), 0);
        chk("midreset_valid", int'(bus.valid), 0);
        chk("midreset_ch_idx", int'(bus.ch_idx), 0);
        chk("midreset_dist_class", int'(bus.dist_class), 63);
        chk("midreset_echo_cycles", int'(bus.echo_cycles), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        continue;
      end
      wait_trig_low(f);
      chk("trigger_width", f - s, TRIG_CYC);
      case (it.kind)
        K_NONE, K_STUCK: begin
          e.ch = it.ch; e.raw = 7; e.cycles = 0; e.vcyc = f + TIMEOUT_CYC;
          expq.push_back(e);
          wait_valid(TIMEOUT_CYC + 20);
          if (it.kind == K_STUCK) bus.echo[it.ch] = 1'b0;
        end
        K_ECHO: begin
          repeat (it.dly) @(posedge clk);
          #1 bus.echo[it.ch] = 1'b1;
          repeat (it.width) @(posedge clk);
          #1 bus.echo[it.ch] = 1'b0;
          e.ch = it.ch; e.raw = raw_of(it.width); e.cycles = it.width; e.vcyc = cyc + 3;
          expq.push_back(e);
          wait_valid(20);
        end
        default: begin
          repeat (it.dly) @(posedge clk);
          #1 bus.echo[it.ch] = 1'b1;
          repeat (it.width) @(posedge clk);
          #1 bus.ctrl = 1'b0;
          @(negedge clk);
          chk("drop_trigger", int'(bus.trigger), 0);
          repeat (20) @(posedge clk);
          #1 bus.echo[it.ch] = 1'b0;
          repeat (20) @(posedge clk);
          chk("drop_ch_idx", int'(bus.ch_idx), it.ch);
          #1 bus.ctrl = 1'b1;
          restart_ref = cyc;
        end
      endcase
      @(negedge clk);
      chk("literal_dist_class", int'(bus.dist_class[it.ch*3 +: 3]), it.lit_dist);
      chk_tol("literal_echo_cycles", int'(bus.echo_cycles[it.ch*CNT_W +: CNT_W]), it.lit_cyc, 2);
    end

    repeat (50) @(negedge clk);
    chk("pending_results", expq.size(), 0);
    finish_run();
  end
endmodule
